// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcode constants and FSM state encoding shared by the
// multi-cycle ALU and its iterative multiply/divide datapath.
package alu_mc_pkg;

  localparam logic [3:0] ALU_CTL_AND  = 4'd0;
  localparam logic [3:0] ALU_CTL_OR   = 4'd1;
  localparam logic [3:0] ALU_CTL_XOR  = 4'd2;
  localparam logic [3:0] ALU_CTL_NAND = 4'd3;
  localparam logic [3:0] ALU_CTL_NOR  = 4'd4;
  localparam logic [3:0] ALU_CTL_ADD  = 4'd5;
  localparam logic [3:0] ALU_CTL_SUB  = 4'd6;
  localparam logic [3:0] ALU_CTL_ADDU = 4'd7;
  localparam logic [3:0] ALU_CTL_SUBU = 4'd8;
  localparam logic [3:0] ALU_CTL_MUL  = 4'd9;
  localparam logic [3:0] ALU_CTL_DIV  = 4'd10;
  localparam logic [3:0] ALU_CTL_SLL  = 4'd11;
  localparam logic [3:0] ALU_CTL_SRL  = 4'd12;
  localparam logic [3:0] ALU_CTL_SRA  = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: shared iterative datapath for unsigned shift-add multiply and
// restoring divide. One WIDTH+1 adder serves both. The first iteration runs
// on the start edge straight from the load values, so WIDTH iterations end
// WIDTH-1 edges after start and done pulses on the following cycle.
// MUL result: {hi, lo}. DIV result: lo = quotient, hi = remainder.
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] load_lo,
  input  logic [WIDTH-1:0] load_m,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done
);

  localparam logic [SHAMT_W:0] LAST = (SHAMT_W+1)'(WIDTH-1);
  localparam logic [SHAMT_W:0] ONE  = (SHAMT_W+1)'(1);

  logic [WIDTH-1:0] m;
  logic             div_mode;
  logic             busy;
  logic [SHAMT_W:0] cnt;

  logic [WIDTH-1:0] cur_hi, cur_lo, cur_m;
  logic             cur_div;
  logic [WIDTH:0]   add_a, add_b;
  logic             add_cin;
  logic [WIDTH+1:0] add_sum;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;

  // One iteration step: shared adder, then shift-add or restoring-subtract update
  always_comb begin
    cur_hi  = start ? '0 : hi;
    cur_lo  = start ? load_lo : lo;
    cur_m   = start ? load_m : m;
    cur_div = start ? is_div : div_mode;
    if (cur_div) begin
      add_a   = {cur_hi, cur_lo[WIDTH-1]};
      add_b   = ~{1'b0, cur_m};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, cur_hi};
      add_b   = cur_lo[0] ? {1'b0, cur_m} : '0;
      add_cin = 1'b0;
    end
    add_sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
    if (cur_div) begin
      // carry out set means the trial subtraction did not borrow
      if (add_sum[WIDTH+1]) begin
        nxt_hi = add_sum[WIDTH-1:0];
        nxt_lo = {cur_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = add_a[WIDTH-1:0];
        nxt_lo = {cur_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = add_sum[WIDTH:1];
      nxt_lo = {add_sum[0], cur_lo[WIDTH-1:1]};
    end
  end

  // Iteration registers and counter; done pulses after the last step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      m        <= '0;
      div_mode <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || busy) begin
        hi <= nxt_hi;
        lo <= nxt_lo;
      end
      if (start) begin
        m        <= load_m;
        div_mode <= is_div;
        busy     <= 1'b1;
        cnt      <= ONE;
      end else if (busy) begin
        if (cnt == LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
          cnt  <= '0;
        end else begin
          cnt <= cnt + ONE;
        end
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU with valid/ready on both sides.
// Optional macro ALU_MC_REM_EN adds the Rem_o signed-remainder output.
// Handshake: a request is taken when Valid_i && Ready_o at a rising edge; a
// result is taken when Valid_o && Ready_i at a rising edge; Valid_o and the
// result stay put until taken.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             Valid_i,
  output logic             Ready_o,
  input  logic [3:0]       ALUCtl_i,
  input  logic [WIDTH-1:0] Op1_i,
  input  logic [WIDTH-1:0] Op2_i,
  output logic             Valid_o,
  input  logic             Ready_i,
  output logic [WIDTH-1:0] Res_o,
  output logic             Zero_o,
  output logic             Overflow_o,
  output logic             DivZero_o,
`ifdef ALU_MC_REM_EN
  output logic [WIDTH-1:0] Rem_o,
`endif
  output alu_state_e       State_o
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  alu_state_e       state;
  logic             valid_q, ovf_q, dz_q;
  logic [WIDTH-1:0] res_q;
  logic             neg_res_q, dvd_neg_q, div_ovf_q;
`ifdef ALU_MC_REM_EN
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] sc_rem;
  logic [WIDTH-1:0] rem_s;
`endif

  logic             accept, is_mul, is_div, start_iter, op1_neg, op2_neg;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] it_hi, it_lo;
  logic             it_done;
  logic [WIDTH:0]   add_u, sub_u;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf, sc_dz;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic             mul_ovf;
  logic [WIDTH-1:0] quot_s;

  assign Ready_o    = (state == ST_IDLE) && (!valid_q || Ready_i);
  assign accept     = Valid_i && Ready_o;
  assign is_mul     = (ALUCtl_i == ALU_CTL_MUL);
  assign is_div     = (ALUCtl_i == ALU_CTL_DIV);
  assign start_iter = accept && (is_mul || (is_div && (Op2_i != '0)));
  assign op1_neg    = Op1_i[WIDTH-1];
  assign op2_neg    = Op2_i[WIDTH-1];
  assign mag1       = op1_neg ? -Op1_i : Op1_i;
  assign mag2       = op2_neg ? -Op2_i : Op2_i;
  assign add_u      = {1'b0, Op1_i} + {1'b0, Op2_i};
  assign sub_u      = {1'b0, Op1_i} - {1'b0, Op2_i};
  assign shamt      = Op2_i[SHAMT_W-1:0];

  alu_mc_iter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_iter (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (start_iter),
    .is_div  (is_div),
    .load_lo (is_div ? mag1 : mag2),
    .load_m  (is_div ? mag2 : mag1),
    .hi      (it_hi),
    .lo      (it_lo),
    .done    (it_done)
  );

  // Single-cycle results, including the divide-by-zero short cut
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_dz  = 1'b0;
`ifdef ALU_MC_REM_EN
    sc_rem = '0;
`endif
    case (ALUCtl_i)
      ALU_CTL_AND:  sc_res = Op1_i & Op2_i;
      ALU_CTL_OR:   sc_res = Op1_i | Op2_i;
      ALU_CTL_XOR:  sc_res = Op1_i ^ Op2_i;
      ALU_CTL_NAND: sc_res = ~(Op1_i & Op2_i);
      ALU_CTL_NOR:  sc_res = ~(Op1_i | Op2_i);
      ALU_CTL_ADD: begin
        sc_res = add_u[WIDTH-1:0];
        sc_ovf = (op1_neg == op2_neg) && (add_u[WIDTH-1] != op1_neg);
      end
      ALU_CTL_SUB: begin
        sc_res = sub_u[WIDTH-1:0];
        sc_ovf = (op1_neg != op2_neg) && (sub_u[WIDTH-1] != op1_neg);
      end
      ALU_CTL_ADDU: begin
        sc_res = add_u[WIDTH-1:0];
        sc_ovf = add_u[WIDTH];
      end
      ALU_CTL_SUBU: begin
        sc_res = sub_u[WIDTH-1:0];
        sc_ovf = sub_u[WIDTH];
      end
      ALU_CTL_DIV: begin
        sc_res = '1;
        sc_dz  = 1'b1;
`ifdef ALU_MC_REM_EN
        sc_rem = Op1_i;
`endif
      end
      ALU_CTL_SLL:  sc_res = Op1_i << shamt;
      ALU_CTL_SRL:  sc_res = Op1_i >> shamt;
      ALU_CTL_SRA:  sc_res = WIDTH'($signed(Op1_i) >>> shamt);
      default:      sc_res = '0;
    endcase
  end

  // Sign fix-up of the iterative magnitudes and MUL range check
  always_comb begin
    prod    = {it_hi, it_lo};
    prod_s  = neg_res_q ? -prod : prod;
    mul_ovf = !((prod_s[2*WIDTH-1:WIDTH-1] == '0) || (prod_s[2*WIDTH-1:WIDTH-1] == '1));
    quot_s  = neg_res_q ? -it_lo : it_lo;
`ifdef ALU_MC_REM_EN
    rem_s   = dvd_neg_q ? -it_hi : it_hi;
`endif
  end

  // Control FSM and registered result/flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      valid_q   <= 1'b0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
      neg_res_q <= 1'b0;
      dvd_neg_q <= 1'b0;
      div_ovf_q <= 1'b0;
`ifdef ALU_MC_REM_EN
      rem_q     <= '0;
`endif
    end else begin
      if (valid_q && Ready_i) valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_iter) begin
            state     <= is_mul ? ST_MUL : ST_DIV;
            neg_res_q <= op1_neg ^ op2_neg;
            dvd_neg_q <= op1_neg;
            div_ovf_q <= (Op1_i == MOST_NEG) && (Op2_i == '1);
          end else if (accept) begin
            res_q   <= sc_res;
            ovf_q   <= sc_ovf;
            dz_q    <= sc_dz;
            valid_q <= 1'b1;
`ifdef ALU_MC_REM_EN
            rem_q   <= sc_rem;
`endif
          end
        end
        ST_MUL: begin
          if (it_done) begin
            res_q   <= prod_s[WIDTH-1:0];
            ovf_q   <= mul_ovf;
            dz_q    <= 1'b0;
            valid_q <= 1'b1;
            state   <= ST_IDLE;
`ifdef ALU_MC_REM_EN
            rem_q   <= '0;
`endif
          end
        end
        ST_DIV: begin
          if (it_done) begin
            res_q   <= quot_s;
            ovf_q   <= div_ovf_q;
            dz_q    <= 1'b0;
            valid_q <= 1'b1;
            state   <= ST_IDLE;
`ifdef ALU_MC_REM_EN
            rem_q   <= rem_s;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Valid_o    = valid_q;
  assign Res_o      = res_q;
  assign Zero_o     = (res_q == '0);
  assign Overflow_o = ovf_q;
  assign DivZero_o  = dz_q;
  assign State_o    = state;
`ifdef ALU_MC_REM_EN
  assign Rem_o      = rem_q;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (WIDTH=32), scoreboard driven.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W  = 32;
  localparam int SH = 5;
  localparam int XW = 2*W + 2;
  localparam logic [W-1:0] MN = 32'h8000_0000;
  localparam longint MAXS = (longint'(1) <<< (W-1)) - 1;
  localparam longint MINS = -(longint'(1) <<< (W-1));

  logic           clk, rst_i, Valid_i, Ready_i;
  logic           Ready_o, Valid_o, Zero_o, Overflow_o, DivZero_o;
  logic [3:0]     ALUCtl_i;
  logic [W-1:0]   Op1_i, Op2_i, Res_o;
  alu_state_e     State_o;
`ifdef ALU_MC_REM_EN
  logic [W-1:0]   Rem_o;
`endif

  logic [XW-1:0]  exp_q[$];
  int             total, bad;
  logic           rdy_s;

  alu_mc #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .Valid_i    (Valid_i),
    .Ready_o    (Ready_o),
    .ALUCtl_i   (ALUCtl_i),
    .Op1_i      (Op1_i),
    .Op2_i      (Op2_i),
    .Valid_o    (Valid_o),
    .Ready_i    (Ready_i),
    .Res_o      (Res_o),
    .Zero_o     (Zero_o),
    .Overflow_o (Overflow_o),
    .DivZero_o  (DivZero_o),
`ifdef ALU_MC_REM_EN
    .Rem_o      (Rem_o),
`endif
    .State_o    (State_o)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: {rem, ovf, divzero, res}
  function automatic logic [XW-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint sa, sb, s, q, r;
    logic [63:0] u;
    logic [W-1:0] res, rem;
    logic ovf, dz;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0; rem = '0; ovf = 1'b0; dz = 1'b0;
    case (op)
      4'd0: res = a & b;
      4'd1: res = a | b;
      4'd2: res = a ^ b;
      4'd3: res = ~(a & b);
      4'd4: res = ~(a | b);
      4'd5: begin s = sa + sb; res = s[W-1:0]; ovf = (s > MAXS) || (s < MINS); end
      4'd6: begin s = sa - sb; res = s[W-1:0]; ovf = (s > MAXS) || (s < MINS); end
      4'd7: begin u = {{(64-W){1'b0}}, a} + {{(64-W){1'b0}}, b}; res = u[W-1:0]; ovf = u[W]; end
      4'd8: begin res = a - b; ovf = (a < b); end
      4'd9: begin s = sa * sb; res = s[W-1:0]; ovf = (s > MAXS) || (s < MINS); end
      4'd10: begin
        if (b == '0) begin res = '1; dz = 1'b1; rem = a; end
        else if (a == MN && b == '1) begin res = MN; ovf = 1'b1; end
        else begin q = sa / sb; r = sa % sb; res = q[W-1:0]; rem = r[W-1:0]; end
      end
      4'd11: res = a << b[SH-1:0];
      4'd12: res = a >> b[SH-1:0];
      4'd13: res = W'($signed(a) >>> b[SH-1:0]);
      default: res = '0;
    endcase
`ifndef ALU_MC_REM_EN
    rem = '0;
`endif
    return {rem, ovf, dz, res};
  endfunction

  // one clock: scoreboard check at negedge, return 1 unit after posedge
  task automatic tick();
    logic [XW-1:0] e, obs;
    logic [W-1:0] rem_obs;
    @(negedge clk);
    rdy_s = Ready_o;
    if (Valid_o && Ready_i) begin
`ifdef ALU_MC_REM_EN
      rem_obs = Rem_o;
`else
      rem_obs = '0;
`endif
      obs = {rem_obs, Overflow_o, DivZero_o, Res_o};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL result_unexpected: got %h, expected no result", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          bad++;
          $display("FAIL result: got {rem,ovf,dz,res}=%h want %h", obs, e);
        end
        total++;
        if (Zero_o !== (e[W-1:0] == '0)) begin
          bad++;
          $display("FAIL zero_flag: got %b want %b", Zero_o, (e[W-1:0] == '0));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // present a request until accepted; pushes the expected result
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      output int waits);
    logic acc;
    ALUCtl_i = op; Op1_i = a; Op2_i = b; Valid_i = 1'b1;
    waits = 0; acc = 1'b0;
    while (!acc && waits <= 200) begin
      tick();
      if (rdy_s) acc = 1'b1;
      else begin
        waits++;
        if (waits >= 2) Ready_i = 1'b1;
      end
    end
    if (acc) exp_q.push_back(model(op, a, b));
    else begin
      total++; bad++;
      $display("FAIL accept_timeout: op=%0d not accepted, wanted acceptance", op);
    end
    Valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    Ready_i = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; Valid_i = 1'b0; Ready_i = 1'b1;
    ALUCtl_i = '0; Op1_i = '0; Op2_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    total++;
    if ({Valid_o, Res_o, Zero_o, Overflow_o, DivZero_o, Ready_o} !== {1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b res=%h z=%b ov=%b dz=%b rdy=%b want 0 0 1 0 0 1",
               Valid_o, Res_o, Zero_o, Overflow_o, DivZero_o, Ready_o);
    end
    total++;
    if (State_o !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", State_o, ST_IDLE); end
  endtask

  task automatic test_add_overflow();
    int w;
    send(ALU_CTL_ADD, 32'h7FFF_FFFF, 32'h1, w);
    total++;
    if ({Valid_o, Res_o, Overflow_o, Zero_o} !== {1'b1, 32'h8000_0000, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL add_ovf: got v=%b res=%h ov=%b z=%b want 1 80000000 1 0", Valid_o, Res_o, Overflow_o, Zero_o);
    end
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    send(ALU_CTL_SUBU, 32'd5, 32'd5, w1);
    total++;
    if ({Res_o, Zero_o, Overflow_o, Valid_o} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL subu_zero: got res=%h z=%b ov=%b v=%b want 0 1 0 1", Res_o, Zero_o, Overflow_o, Valid_o);
    end
    send(ALU_CTL_SRA, 32'h8000_0000, 32'd4, w2);
    total++;
    if (Res_o !== 32'hF800_0000) begin bad++; $display("FAIL sra_b2b: got %h want f8000000", Res_o); end
    total++;
    if (w1 != 0 || w2 != 0) begin bad++; $display("FAIL b2b_ready: got waits %0d/%0d want 0/0", w1, w2); end
  endtask

  // run one long op and check latency and Ready_o low while busy
  task automatic long_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input string name);
    int w, n;
    logic rdy_seen;
    send(op, a, b, w);
    n = 0; rdy_seen = 1'b0;
    while (!Valid_o && n < W + 10) begin
      if (Ready_o !== 1'b0) rdy_seen = 1'b1;
      tick();
      n++;
    end
    total++;
    if (n != W) begin bad++; $display("FAIL %s_latency: got %0d cycles want %0d", name, n, W); end
    total++;
    if (rdy_seen) begin bad++; $display("FAIL %s_ready_busy: got Ready_o=1 while busy want 0", name); end
  endtask

  task automatic test_mul();
    long_op(ALU_CTL_MUL, -32'sd3, 32'd7, "mul_neg");
    total++;
    if ({Res_o, Overflow_o} !== {32'hFFFF_FFEB, 1'b0}) begin
      bad++; $display("FAIL mul_neg_res: got %h ov=%b want ffffffeb 0", Res_o, Overflow_o);
    end
    long_op(ALU_CTL_MUL, 32'h1_0000, 32'h1_0000, "mul_big");
    total++;
    if ({Res_o, Overflow_o} !== {32'h0, 1'b1}) begin
      bad++; $display("FAIL mul_big_res: got %h ov=%b want 0 1", Res_o, Overflow_o);
    end
  endtask

  task automatic test_div();
    int w;
    long_op(ALU_CTL_DIV, -32'sd7, 32'd2, "div_neg");
    total++;
    if (Res_o !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_neg_res: got %h want fffffffd", Res_o); end
`ifdef ALU_MC_REM_EN
    total++;
    if (Rem_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_neg_rem: got %h want ffffffff", Rem_o); end
`endif
    send(ALU_CTL_DIV, 32'd9, 32'd0, w);
    total++;
    if ({Valid_o, Res_o, DivZero_o, Overflow_o} !== {1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL div_zero: got v=%b res=%h dz=%b ov=%b want 1 ffffffff 1 0", Valid_o, Res_o, DivZero_o, Overflow_o);
    end
    long_op(ALU_CTL_DIV, MN, 32'hFFFF_FFFF, "div_ovf");
    total++;
    if ({Res_o, Overflow_o} !== {MN, 1'b1}) begin
      bad++; $display("FAIL div_ovf_res: got %h ov=%b want 80000000 1", Res_o, Overflow_o);
    end
  endtask

  task automatic test_hold();
    int w;
    drain();
    Ready_i = 1'b0;
    send(ALU_CTL_ADD, 32'd3, 32'd4, w);
    Valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ALUCtl_i = 4'($urandom_range(0, 15));
      Op1_i = $urandom(); Op2_i = $urandom();
      tick();
      total++;
      if ({Valid_o, Res_o, Overflow_o, DivZero_o, Ready_o} !== {1'b1, 32'd7, 1'b0, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL hold: got v=%b res=%h ov=%b dz=%b rdy=%b want 1 7 0 0 0",
                 Valid_o, Res_o, Overflow_o, DivZero_o, Ready_o);
      end
    end
    Valid_i = 1'b0;
    Ready_i = 1'b1;
    tick();
    tick();
    total++;
    if (Valid_o !== 1'b0 || exp_q.size() != 0) begin
      bad++; $display("FAIL hold_release: got v=%b pending=%0d want 0 0", Valid_o, exp_q.size());
    end
  endtask

  task automatic test_random();
    int w, sel;
    logic [3:0] op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom(); b = $urandom();
      sel = $urandom_range(0, 3);
      if (sel == 0) b = W'($urandom_range(0, 9));
      if (sel == 1) begin a = W'($urandom_range(0, 50)); b = -W'($urandom_range(1, 9)); end
      Ready_i = ($urandom_range(0, 3) != 0);
      send(op, a, b, w);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int w;
    Ready_i = 1'b1;
    send(ALU_CTL_DIV, 32'd100, 32'd7, w);
    repeat (10) tick();
    #2 rst_i = 1'b1;
    #1;
    total++;
    if (Valid_o !== 1'b0 || State_o !== ST_IDLE) begin
      bad++; $display("FAIL reset_mid: got v=%b state=%0d want 0 %0d", Valid_o, State_o, ST_IDLE);
    end
    exp_q.delete();
    @(posedge clk);
    #1 rst_i = 1'b0;
    total++;
    if (Ready_o !== 1'b1) begin bad++; $display("FAIL reset_mid_ready: got %b want 1", Ready_o); end
    send(ALU_CTL_ADD, 32'd1, 32'd2, w);
    total++;
    if ({Valid_o, Res_o} !== {1'b1, 32'd3}) begin
      bad++; $display("FAIL reset_mid_add: got v=%b res=%h want 1 3", Valid_o, Res_o);
    end
    drain();
  endtask

  initial begin
    total = 0; bad = 0; rdy_s = 1'b0;
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_mul();
    test_div();
    test_hold();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU for the execute stage.
- Single-cycle logic, add/sub and shift ops have a registered output. Signed MUL and DIV run iteratively over WIDTH cycles.
- Valid/ready handshake on both sides so the pipeline can stall on long ops.
- Replaces the purely combinational ALU where WIDTH > 32 or timing forbids a single-cycle multiplier/divider.

Parameters:
- WIDTH, 32, operand/result width (>= 8, even)
- SHAMT_W, $clog2(WIDTH), shift-amount bits taken from Op2_i[SHAMT_W-1:0]

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- Valid_i  in  1  request valid
- Ready_o  out  1  request accepted when Valid_i && Ready_o at rising edge
- ALUCtl_i  in  4  operation code
- Op1_i  in  WIDTH  operand 1 (dividend/multiplicand)
- Op2_i  in  WIDTH  operand 2 (divisor/multiplier/shift amount)
- Valid_o  out  1  result valid; held until consumed
- Ready_i  in  1  downstream accepts result when Valid_o && Ready_i
- Res_o  out  WIDTH  result
- Zero_o  out  1  Res_o == 0
- Overflow_o  out  1  per-op overflow flag
- DivZero_o  out  1  DIV with Op2 == 0

Behaviour:
- Reset (async, rst_i=1): state IDLE; Valid_o=0, Res_o=0, Overflow_o=0, DivZero_o=0; Zero_o=1 (derived from Res_o); Ready_o=1 after deassert.
- FSM states: IDLE, MUL, DIV.
  - IDLE -> MUL on accepted MUL.
  - IDLE -> DIV on accepted DIV with Op2 != 0.
  - MUL/DIV -> IDLE after WIDTH iteration cycles, loading result and setting Valid_o.
- Ready_o = (state==IDLE) && (!Valid_o || Ready_i). Back-to-back single-cycle ops sustain 1 op/cycle.
- Operands and opcode are latched on accept; input changes during MUL/DIV have no effect.
- Latency:
  - Single-cycle ops: Valid_o rises 1 cycle after accept.
  - MUL and DIV: WIDTH+1 cycles.
  - DIV by zero: 1 cycle.
- Output hold: Res_o and flags stay stable while Valid_o && !Ready_i.
- Valid_o clears on consume unless a new result loads the same edge.
- Opcodes (ALU_CTL_*):
  - AND=0, OR=1, XOR=2, NAND=3, NOR=4
  - ADD=5, SUB=6, ADDU=7, SUBU=8
  - MUL=9, DIV=10
  - SLL=11, SRL=12, SRA=13
  - 14/15 reserved: Res_o=0, Overflow_o=0, 1-cycle.
- Overflow_o:
  - ADD/SUB: signed two's-complement overflow.
  - ADDU: carry out. SUBU: borrow (Op1 < Op2 unsigned).
  - MUL: signed product does not fit in WIDTH bits.
  - DIV: Op1 = most-negative and Op2 = -1; Res_o = most-negative.
  - 0 for all other ops.
- MUL: shift-add on magnitudes, one multiplier bit per cycle, 2*WIDTH accumulator. Negate if signs differ. Res_o = low WIDTH bits.
- DIV:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Op2==0: Res_o = all ones, DivZero_o=1, Overflow_o=0, no iteration.
- Shifts: shift amount = Op2_i[SHAMT_W-1:0]. SRA replicates Op1 MSB.
- Iteration counter is SHAMT_W+1 bits, counts 0..WIDTH-1; no wrap beyond.
- Reset mid-MUL/DIV aborts the op, returns to IDLE, and drops any pending result.

Optional Feature:
- Macro: ALU_MC_REM_EN.
- Defined:
  - Extra port Rem_o out WIDTH.
  - DIV: Rem_o = signed remainder; Op2==0 gives Rem_o = Op1.
  - Other ops: Rem_o = 0.
  - Held with Res_o; reset 0.
- Undefined: no Rem_o port and no remainder register. The divider still computes the remainder internally.

Decomposition:
- Shared package/include (Const.v style): ALU_CTL_* opcode constants and FSM state encodings.
- One natural sub-module: alu_mc_iter. It holds the shared shift-add / restoring-subtract datapath with its counter and shares one WIDTH+1 adder between MUL and DIV.
- Top level keeps the handshake, the single-cycle ops and the sign fix-up.

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF+1 -> next cycle: Valid_o=1, Res_o=0x80000000, Overflow_o=1, Zero_o=0.
- SUBU 5-5 then back-to-back SRA 0x80000000>>4 with Ready_i=1 -> Res_o=0, Zero_o=1, Overflow_o=0; next cycle Res_o=0xF8000000; Ready_o never drops.
- MUL -3 * 7 -> Ready_o=0 for 32 cycles; Res_o=0xFFFFFFEB (-21) at cycle 33, Overflow_o=0. MUL 0x10000*0x10000 -> Res_o=0, Overflow_o=1.
- DIV -7/2 -> Res_o=0xFFFFFFFD (-3), Rem_o=0xFFFFFFFF with ALU_MC_REM_EN. DIV 9/0 -> 1 cycle: Res_o=0xFFFFFFFF, DivZero_o=1. DIV 0x80000000/-1 -> Res_o=0x80000000, Overflow_o=1.
- Hold Ready_i=0 after result, toggle inputs -> Res_o and flags stable, Ready_o=0, no new accept until consume.
- Assert rst_i 10 cycles into a DIV -> Valid_o=0 immediately (async); after release, Ready_o=1 and a fresh ADD 1+2 returns 3.
